ahb_slave_mem: RTL and testbench

AHB-Lite responder: a DEPTH-word, 32-bit, little-endian register memory with programmable wait states and a two-cycle ERROR response. It is the slave side of the response path: its HRDATA/HRESP/HREADYOUT feed one input slot of the slave-to-master response multiplexor. It follows the standard AHB address/data-phase pipeline.

---
 rtl/ahb_pkg.sv | 24 ++
 rtl/ahb_byte_strobe.sv | 30 +++
 rtl/ahb_slave_mem.sv | 129 ++++++++++++
 tb/tb_ahb_slave_mem.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the responder FSM state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } ahb_state_t;

endpackage

// File: rtl/ahb_byte_strobe.sv
// Maps transfer size and low address bits to a little-endian byte-lane
// write strobe, flagging misaligned or unsupported sizes.
module ahb_byte_strobe
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] strobe,
  output logic       align_err
);

  // Lane selection per size; anything wider than a word is rejected
  always_comb begin
    strobe    = 4'b0000;
    align_err = 1'b0;
    case (hsize)
      HSIZE_BYTE: strobe = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        strobe    = addr_lo[1] ? 4'b1100 : 4'b0011;
        align_err = addr_lo[0];
      end
      HSIZE_WORD: begin
        strobe    = 4'b1111;
        align_err = (addr_lo != 2'b00);
      end
      default: align_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite register-memory responder with programmable wait states and a
// two-cycle ERROR response. Outputs are decoded from the FSM state only,
// so HREADY may be fed straight back from HREADYOUT without a loop.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
)(
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        HREADYOUT
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  ahb_state_t state, state_next;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx_q;
  logic          write_q;
  logic [3:0]    strobe_q;
  logic [3:0]    wait_cnt;

  logic [3:0] strobe;
  logic       align_err;
  logic       active;
  logic       can_accept;
  logic       accept;
  logic       addr_err;

  ahb_byte_strobe u_strobe (
    .hsize     (HSIZE),
    .addr_lo   (HADDR[1:0]),
    .strobe    (strobe),
    .align_err (align_err)
  );

  // Address-phase decode: is a transfer being accepted and is it legal
  always_comb begin
    active = 1'b0;
    case (HTRANS)
      HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
    endcase
    can_accept = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
    accept     = HSEL && active && HREADY && can_accept;
    addr_err   = (HADDR[31:AW+2] != '0)
              || (32'(HADDR[AW+1:2]) >= 32'(DEPTH))
              || align_err;
  end

  // Next-state and response outputs
  always_comb begin
    state_next = state;
    HREADYOUT  = 1'b1;
    HRESP      = HRESP_OKAY;
    HRDATA     = '0;
    case (state)
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (wait_cnt == 4'd0) state_next = ST_DATA;
      end
      ST_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = HRESP_ERROR;
        state_next = ST_ERR2;
      end
      default: begin
        if (state == ST_ERR2) HRESP = HRESP_ERROR;
        if (state == ST_DATA && !write_q) HRDATA = mem[idx_q];
        if (accept) begin
          if (addr_err)              state_next = ST_ERR1;
          else if (WAIT_STATES == 0) state_next = ST_DATA;
          else                       state_next = ST_WAIT;
        end else begin
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  // State register
  always_ff @(posedge HCLK) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Wait-state counter, loaded at acceptance and run down while waiting
  always_ff @(posedge HCLK) begin
    if (HRESET)                                wait_cnt <= 4'd0;
    else if (accept)                           wait_cnt <= WAIT_LOAD;
    else if (state == ST_WAIT && wait_cnt != 0) wait_cnt <= wait_cnt - 4'd1;
  end

  // Capture of the address-phase control for use in the data phase
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      idx_q    <= '0;
      write_q  <= 1'b0;
      strobe_q <= 4'b0000;
    end else if (accept) begin
      idx_q    <= HADDR[AW+1:2];
      write_q  <= HWRITE;
      strobe_q <= strobe;
    end
  end

  // Memory array: cleared on reset, byte lanes committed as a DATA write closes
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == ST_DATA && write_q) begin
      for (int b = 0; b < 4; b++)
        if (strobe_q[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Self-checking bench: two responders (0 and 2 wait states) driven by
// directed and random transfers, checked against a simple memory model.
module tb_ahb_slave_mem;
  import ahb_pkg::*;

  logic        hclk = 1'b0;
  logic        hreset    [2];
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [31:0] hwdata    [2];
  logic [31:0] hrdata    [2];
  logic        hresp     [2];
  logic        hreadyout [2];

  logic [31:0] ref_mem [2][256];
  int errors = 0;
  int checks = 0;

  always #5 hclk = ~hclk;

  ahb_slave_mem #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
    .HCLK(hclk), .HRESET(hreset[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
    .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]),
    .HREADY(hreadyout[0]), .HRDATA(hrdata[0]), .HRESP(hresp[0]), .HREADYOUT(hreadyout[0])
  );

  ahb_slave_mem #(.DEPTH(256), .WAIT_STATES(2)) dut2 (
    .HCLK(hclk), .HRESET(hreset[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
    .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]),
    .HREADY(hreadyout[1]), .HRDATA(hrdata[1]), .HRESP(hresp[1]), .HREADYOUT(hreadyout[1])
  );

  function automatic int waitsFor(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic bit isErr(input logic [31:0] addr, input logic [2:0] size);
    return (addr[31:10] != 0) || (size > 3'd2)
        || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] laneMask(input logic [31:0] addr, input logic [2:0] size);
    logic [63:0] m;
    m = ((64'd1 << (8 * (1 << size))) - 64'd1) << (8 * addr[1:0]);
    return m[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int d, input logic wr, input logic [31:0] addr, input logic [2:0] size);
    hsel[d]   = 1'b1;
    htrans[d] = HTRANS_NONSEQ;
    haddr[d]  = addr;
    hwrite[d] = wr;
    hsize[d]  = size;
  endtask

  task automatic idleBus(input int d);
    hsel[d]   = 1'b0;
    htrans[d] = HTRANS_IDLE;
    haddr[d]  = '0;
    hwrite[d] = 1'b0;
    hsize[d]  = HSIZE_WORD;
  endtask

  // Called just after an accepting edge; returns at the negedge of the ready cycle
  task automatic dataPhase(input int d, output int waits, output logic first_resp,
                           output logic last_resp, output logic [31:0] rdata);
    waits = 0;
    @(negedge hclk);
    first_resp = hresp[d];
    while (hreadyout[d] !== 1'b1 && waits < 40) begin
      waits++;
      @(negedge hclk);
    end
    last_resp = hresp[d];
    rdata     = hrdata[d];
  endtask

  task automatic transfer(input int d, input logic wr, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata, input string tag);
    bit          err;
    int          waits;
    logic        fr, lr;
    logic [31:0] rd, exp_rd, m;
    err = isErr(addr, size);
    exp_rd = (err || wr) ? 32'h0 : ref_mem[d][addr[9:2]];
    applyStimulus(d, wr, addr, size);
    @(posedge hclk); #1;
    idleBus(d);
    hwdata[d] = wdata;
    dataPhase(d, waits, fr, lr, rd);
    checkOutput({tag, "_waits"}, 32'(waits), err ? 32'd1 : 32'(waitsFor(d)));
    checkOutput({tag, "_resp_first"}, {31'b0, fr}, {31'b0, err});
    checkOutput({tag, "_resp_last"}, {31'b0, lr}, {31'b0, err});
    checkOutput({tag, "_rdata"}, rd, exp_rd);
    @(posedge hclk); #1;
    if (!err && wr) begin
      m = laneMask(addr, size);
      ref_mem[d][addr[9:2]] = (ref_mem[d][addr[9:2]] & ~m) | (wdata & m);
    end
  endtask

  // Write immediately followed by a pipelined read of the same word
  task automatic pipeWriteRead(input int d, input logic [31:0] addr, input logic [31:0] data, input string tag);
    int          waits;
    logic        fr, lr;
    logic [31:0] rd;
    applyStimulus(d, 1'b1, addr, HSIZE_WORD);
    @(posedge hclk); #1;
    hwdata[d] = data;
    applyStimulus(d, 1'b0, addr, HSIZE_WORD);
    dataPhase(d, waits, fr, lr, rd);
    checkOutput({tag, "_wr_waits"}, 32'(waits), 32'(waitsFor(d)));
    checkOutput({tag, "_wr_rdata"}, rd, 32'h0);
    @(posedge hclk); #1;
    idleBus(d);
    ref_mem[d][addr[9:2]] = data;
    dataPhase(d, waits, fr, lr, rd);
    checkOutput({tag, "_rd_waits"}, 32'(waits), 32'(waitsFor(d)));
    checkOutput({tag, "_rd_resp"}, {31'b0, lr}, {31'b0, HRESP_OKAY});
    checkOutput({tag, "_rd_rdata"}, rd, ref_mem[d][addr[9:2]]);
    @(posedge hclk); #1;
  endtask

  // Selected but IDLE/BUSY: zero-wait OKAY and nothing written
  task automatic idleSelected(input int d, input logic [1:0] tr, input string tag);
    hsel[d] = 1'b1; htrans[d] = tr; hwrite[d] = 1'b1;
    haddr[d] = 32'h10; hsize[d] = HSIZE_WORD;
    @(posedge hclk); #1;
    idleBus(d);
    hwdata[d] = 32'h55555555;
    @(negedge hclk);
    checkOutput({tag, "_ready"}, {31'b0, hreadyout[d]}, 32'd1);
    checkOutput({tag, "_resp"}, {31'b0, hresp[d]}, 32'd0);
    checkOutput({tag, "_rdata"}, hrdata[d], 32'h0);
    @(posedge hclk); #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;

    for (int d = 0; d < 2; d++) begin
      hreset[d] = 1'b1;
      hwdata[d] = '0;
      idleBus(d);
      for (int i = 0; i < 256; i++) ref_mem[d][i] = '0;
    end
    repeat (3) @(posedge hclk);
    #1;
    hreset[0] = 1'b0;
    hreset[1] = 1'b0;
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      checkOutput("reset_ready", {31'b0, hreadyout[d]}, 32'd1);
      checkOutput("reset_resp", {31'b0, hresp[d]}, 32'd0);
      checkOutput("reset_rdata", hrdata[d], 32'h0);
    end
    @(posedge hclk); #1;

    $display("[TB] word write/read, zero wait");
    transfer(0, 1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, "w_deadbeef");
    transfer(0, 1'b0, 32'h10, HSIZE_WORD, 32'h0, "r_deadbeef");

    $display("[TB] byte and halfword lanes");
    transfer(0, 1'b1, 32'h21, HSIZE_BYTE, 32'hABABABAB, "w_byte");
    transfer(0, 1'b0, 32'h20, HSIZE_WORD, 32'h0, "r_byte");
    transfer(0, 1'b1, 32'h22, HSIZE_HALF, 32'h12341234, "w_half");
    transfer(0, 1'b0, 32'h20, HSIZE_WORD, 32'h0, "r_half");

    $display("[TB] error responses");
    transfer(0, 1'b0, 32'h400, HSIZE_WORD, 32'h0, "r_oob");
    transfer(0, 1'b1, 32'h02, HSIZE_WORD, 32'hFFFFFFFF, "w_misalign");
    transfer(0, 1'b0, 32'h00, HSIZE_WORD, 32'h0, "r_after_err");

    $display("[TB] selected idle and busy");
    idleSelected(0, HTRANS_IDLE, "sel_idle");
    idleSelected(0, HTRANS_BUSY, "sel_busy");
    transfer(0, 1'b0, 32'h10, HSIZE_WORD, 32'h0, "r_after_idle");

    $display("[TB] pipelined write then read");
    pipeWriteRead(0, 32'h40, 32'hCAFEF00D, "pipe_w0");
    transfer(1, 1'b0, 32'h10, HSIZE_WORD, 32'h0, "r_w2");
    pipeWriteRead(1, 32'h44, 32'h0BADC0DE, "pipe_w2");

    $display("[TB] reset during wait state");
    transfer(1, 1'b1, 32'h30, HSIZE_WORD, 32'h11112222, "w_pre_reset");
    applyStimulus(1, 1'b1, 32'h30, HSIZE_WORD);
    @(posedge hclk); #1;
    idleBus(1);
    hwdata[1] = 32'h99999999;
    @(negedge hclk);
    checkOutput("mid_wait_ready", {31'b0, hreadyout[1]}, 32'd0);
    hreset[1] = 1'b1;
    @(posedge hclk); #1;
    hreset[1] = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[1][i] = '0;
    @(negedge hclk);
    checkOutput("post_reset_ready", {31'b0, hreadyout[1]}, 32'd1);
    checkOutput("post_reset_resp", {31'b0, hresp[1]}, 32'd0);
    checkOutput("post_reset_rdata", hrdata[1], 32'h0);
    @(posedge hclk); #1;
    transfer(1, 1'b0, 32'h30, HSIZE_WORD, 32'h0, "r_post_reset");

    $display("[TB] random transfers");
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 25; n++) begin
        a = ($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
        if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(10, 31));
        sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        transfer(d, 1'($urandom_range(0, 1)), a, sz, $urandom(), "rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
